// File: rtl/fetch_sequencer.sv
// Purpose: PC owner and instruction fetch controller for the five-stage MIPS pipeline; optional perf counters under FETCH_PERF_EN.
// Latency: InstrAddr = PC (combinational); the fetched word reaches IF/ID one clock after the PC update; redirects cost one bubble.
// Backpressure: Stall holds PC, IF/ID and EPC; an Exception overrides Stall; a deferred interrupt is re-sampled every cycle.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpEn,
    input  logic [31:0] JumpTarget,
    input  logic        Interrupt,
    input  logic        Exception,
    input  logic [31:0] ExcPC,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrIn,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_Valid,
    output logic [31:0] EPC,
    output logic        KernelMode,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
);

    // Source of the next PC, one per priority level.
    typedef enum logic [2:0] {
        SRC_EXC    = 3'd0,
        SRC_IRQ    = 3'd1,
        SRC_HOLD   = 3'd2,
        SRC_BRANCH = 3'd3,
        SRC_JUMP   = 3'd4,
        SRC_SEQ    = 3'd5
    } pc_src_t;

    pc_src_t     pc_src;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_seq;
    logic        irq_accept;

    // The branch target's bit 31 is replaced by the current mode bit; branches never change mode.
    logic        unused_branch_msb;
    assign unused_branch_msb = BranchTarget[31];

    assign InstrAddr  = pc;
    assign KernelMode = pc[31];

    // Sequential increment wraps inside the low 31 bits so the mode bit is preserved.
    assign pc_seq = {pc[31], pc[30:0] + 31'd4};

    // Interrupt acceptance: user mode only, and only on a cycle with no stall or control-flow redirect.
    always_comb begin
        irq_accept = Interrupt && !pc[31] && !Stall && !BranchTaken && !JumpEn;
    end

    // Fixed-priority arbitration of the next-PC source.
    always_comb begin
        pc_src = SRC_SEQ;
        if (Exception) begin
            pc_src = SRC_EXC;
        end else if (irq_accept) begin
            pc_src = SRC_IRQ;
        end else if (Stall) begin
            pc_src = SRC_HOLD;
        end else if (BranchTaken) begin
            pc_src = SRC_BRANCH;
        end else if (JumpEn) begin
            pc_src = SRC_JUMP;
        end
    end

    // Next-PC mux driven by the selected source.
    always_comb begin
        pc_next = pc_seq;
        case (pc_src)
            SRC_EXC:    pc_next = EXC_VECTOR;
            SRC_IRQ:    pc_next = IRQ_VECTOR;
            SRC_HOLD:   pc_next = pc;
            SRC_BRANCH: pc_next = {pc[31], BranchTarget[30:0]};
            SRC_JUMP:   pc_next = JumpTarget;
            default:    pc_next = pc_seq;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID register: load on sequential fetch, hold on stall, otherwise insert a nop bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_Instruction <= 32'h0;
            IF_ID_PC          <= 32'h0;
            IF_ID_Valid       <= 1'b0;
        end else begin
            case (pc_src)
                SRC_HOLD: begin
                    IF_ID_Instruction <= IF_ID_Instruction;
                    IF_ID_PC          <= IF_ID_PC;
                    IF_ID_Valid       <= IF_ID_Valid;
                end
                SRC_SEQ: begin
                    IF_ID_Instruction <= InstrIn;
                    IF_ID_PC          <= pc;
                    IF_ID_Valid       <= 1'b1;
                end
                default: begin
                    IF_ID_Instruction <= 32'h0;
                    IF_ID_PC          <= pc;
                    IF_ID_Valid       <= 1'b0;
                end
            endcase
        end
    end

    // Trap return address: the instruction after the faulting one, or the PC an interrupt preempted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EPC <= 32'h0;
        end else if (pc_src == SRC_EXC) begin
            EPC <= ExcPC + 32'd4;
        end else if (pc_src == SRC_IRQ) begin
            EPC <= pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Performance counters: real fetches, and stall cycles not overridden by an exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (pc_src == SRC_SEQ) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (Stall && !Exception) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign FetchCount = fetch_cnt;
    assign StallCount = stall_cnt;
`else
    assign FetchCount = 32'h0;
    assign StallCount = 32'h0;
`endif

endmodule
